// File: rtl/rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rd_arb_pkg
// Brief    : Shared types and helpers for the read-request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rd_arb_pkg;

    // Largest requester count the arbiter supports.
    localparam int MAX_REQ = 8;

    // Arbiter sequencing states, explicitly encoded.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RELEASE = 3'd3,
        ABORT   = 3'd4
    } arb_state_t;

    // One-hot expansion of a requester index.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rd_rr_pick
// Brief    : Combinational round-robin picker. Searches upward from ptr+1
//            (with wrap) and returns the first requesting index.
// Revision : 1.0 - initial release
// ============================================================================
module rd_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     valid
);

    localparam int IW = $clog2(N_REQ);

    // Scan candidates from farthest to nearest so the nearest set bit wins.
    always_comb begin
        logic [IW-1:0] w_cand;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_cand = IW'((int'(ptr) + i) % N_REQ);
            if (req[w_cand]) begin
                idx   = w_cand;
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rd_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rd_req_arbiter
// Brief    : Round-robin arbiter sharing one single-read bus controller
//            between N_REQ requesters, with a watchdog that aborts reads
//            stuck in wait states and reports err to the owner.
// Revision : 1.0 - initial release
// ============================================================================
module rd_req_arbiter
    import rd_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         err,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     go,
    input  logic                     eng_rd,
    input  logic                     eng_ds,
    output logic                     eng_abort
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_CNT_MAX  = CW'(TIMEOUT);
    localparam logic [IW-1:0] C_PTR_RST  = IW'(N_REQ - 1);

    arb_state_t      r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_valid;
    logic            w_timeout;
    logic [CW-1:0]   w_cnt_inc;
    logic [N_REQ-1:0] w_owner_oh;

    rd_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    // Watchdog fires on the last allowed cycle unless data strobe arrives;
    // >= keeps a saturated counter from ever slipping past the abort.
    assign w_timeout = (r_cnt >= C_CNT_LAST) && !eng_ds;
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Sequencer: grant, issue, wait for data, then release or abort.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= C_PTR_RST;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_state <= ABORT;
                    end else if (eng_rd) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (eng_ds) begin
                        r_state <= RELEASE;
                    end else if (w_timeout) begin
                        r_state <= ABORT;
                    end
                end
                RELEASE: begin
                    r_ptr   <= r_owner;
                    r_state <= IDLE;
                end
                ABORT: begin
                    r_ptr   <= r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Moore output decode from registered state and owner only.
    assign w_owner_oh = N_REQ'(onehot(3'(r_owner)));
    assign gnt        = (r_state != IDLE)    ? w_owner_oh : '0;
    assign done       = (r_state == RELEASE) ? w_owner_oh : '0;
    assign err        = (r_state == ABORT)   ? w_owner_oh : '0;
    assign owner      = r_owner;
    assign busy       = (r_state != IDLE);
    assign go         = (r_state == ISSUE);
    assign eng_abort  = (r_state == ABORT);

endmodule
`default_nettype wire
